// File: rtl/assist_pwm_controller.sv
// assist_pwm_controller: heart-rate/incline assisted motor duty computation with ramp-limited glitch-free PWM and HR watchdog
module assist_pwm_controller #(
  parameter int DATA_W          = 18,
  parameter int HR_W            = 8,
  parameter int PWM_W           = 10,
  parameter int HR_SHIFT        = 4,
  parameter int TILT_SHIFT      = 4,
  parameter int INCLINE_AXIS    = 0,
  parameter int RAMP_UP         = 8,
  parameter int RAMP_DOWN       = 32,
  parameter int TIMEOUT_PERIODS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               Mode,
  input  logic [PWM_W-1:0]         FixedDuty,
  input  logic signed [DATA_W-1:0] AccelX,
  input  logic signed [DATA_W-1:0] AccelY,
  input  logic signed [DATA_W-1:0] AccelZ,
  input  logic [HR_W-1:0]          HeartRate,
  input  logic                     HeartRateValid,
  input  logic [HR_W-1:0]          HeartRateSetting,
  input  logic                     SampleValid,
  output logic                     SampleReady,
  output logic [PWM_W-1:0]         Duty,
  output logic                     Fault,
  output logic                     PWMOut
);
  localparam int WW  = HR_W + HR_SHIFT + DATA_W + PWM_W + 1;
  localparam int WDW = $clog2(TIMEOUT_PERIODS + 1);
  localparam logic [PWM_W-1:0] DMAX   = '1;
  localparam logic [WW-1:0]    DMAX_W = WW'(DMAX);
  localparam logic [PWM_W-1:0] RU     = PWM_W'(RAMP_UP);
  localparam logic [PWM_W-1:0] RD     = PWM_W'(RAMP_DOWN);
  localparam logic [WDW-1:0]   WD_MAX = WDW'(TIMEOUT_PERIODS);
  typedef enum logic [2:0] {IDLE, CAPTURE, HR_TERM, TILT_TERM, CLAMP} state_t;
  state_t state, state_nx;
  logic [1:0] mode_q;
  logic [PWM_W-1:0] fixed_q, hr_term, tilt, target, cnt, up, dn;
  logic signed [DATA_W-1:0] accel_q, accel_sel;
  logic [HR_W-1:0] hr_q, set_q;
  logic signed [HR_W:0] err;
  logic [WW-1:0] hr_w, tilt_w;
  logic [PWM_W:0] sum;
  logic [WDW-1:0] wd;
  logic wrap, kill;
  always_comb begin
    accel_sel = INCLINE_AXIS == 1 ? AccelY : INCLINE_AXIS == 2 ? AccelZ : AccelX;
    err       = $signed({1'b0, hr_q}) - $signed({1'b0, set_q});
    hr_w      = err > 0 ? (WW'(err[HR_W-1:0]) << HR_SHIFT) : '0;
    tilt_w    = accel_q > 0 ? (WW'(accel_q[DATA_W-1:0]) >> TILT_SHIFT) : '0;
    sum       = {1'b0, hr_term} + {1'b0, tilt};
    wrap      = cnt == DMAX;
    kill      = Mode == 2'd0 || (Fault && Mode[1]);
    up        = target - Duty;
    dn        = Duty - target;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (SampleValid ? CAPTURE : IDLE) :
               state == CLAMP ? IDLE : state_t'(state + 3'd1);
  always_comb SampleReady = state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q  <= '0;
      fixed_q <= '0;
      accel_q <= '0;
      set_q   <= '0;
      hr_term <= '0;
      tilt    <= '0;
      target  <= '0;
    end else begin
      if (state == CAPTURE) begin
        mode_q  <= Mode;
        fixed_q <= FixedDuty;
        accel_q <= accel_sel;
        set_q   <= HeartRateSetting;
      end
      if (state == HR_TERM) hr_term <= hr_w > DMAX_W ? DMAX : hr_w[PWM_W-1:0];
      if (state == TILT_TERM)
        tilt <= mode_q != 2'd3 ? '0 : tilt_w > DMAX_W ? DMAX : tilt_w[PWM_W-1:0];
      // A faulted heart-rate channel must never produce a heart-driven target
      if (state == CLAMP)
        target <= (Fault && mode_q[1]) ? '0 :
                  mode_q == 2'd1 ? fixed_q :
                  mode_q == 2'd2 ? hr_term :
                  mode_q == 2'd3 ? (sum[PWM_W] ? DMAX : sum[PWM_W-1:0]) : '0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hr_q  <= '0;
      wd    <= '0;
      Fault <= 1'b0;
    end else if (HeartRateValid) begin
      hr_q  <= HeartRate;
      wd    <= '0;
      Fault <= 1'b0;
    end else if (wrap && wd != WD_MAX) begin
      wd    <= wd + 1'b1;
      Fault <= wd == WD_MAX - 1'b1;
    end
  // Duty only changes on the wrap so each period is generated from a single value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      Duty   <= '0;
      PWMOut <= 1'b0;
    end else begin
      cnt    <= cnt + 1'b1;
      PWMOut <= cnt < Duty;
      if (wrap)
        Duty <= kill ? '0 :
                target > Duty ? Duty + (up > RU ? RU : up) :
                target < Duty ? Duty - (dn > RD ? RD : dn) : Duty;
    end
endmodule

// File: tb/tb_assist_pwm_controller.sv
// tb_assist_pwm_controller: directed self-checking bench for assist_pwm_controller
module tb_assist_pwm_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] Mode;
  logic [9:0] FixedDuty, Duty, duty_y;
  logic signed [17:0] AccelX, AccelY, AccelZ;
  logic [7:0] HeartRate, HeartRateSetting;
  logic HeartRateValid, SampleValid, SampleReady, Fault, PWMOut, ready_y, fault_y, pwm_y;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assist_pwm_controller dut (
    .clk(clk), .rst_n(rst_n), .Mode(Mode), .FixedDuty(FixedDuty),
    .AccelX(AccelX), .AccelY(AccelY), .AccelZ(AccelZ),
    .HeartRate(HeartRate), .HeartRateValid(HeartRateValid), .HeartRateSetting(HeartRateSetting),
    .SampleValid(SampleValid), .SampleReady(SampleReady), .Duty(Duty), .Fault(Fault), .PWMOut(PWMOut)
  );
  assist_pwm_controller #(.INCLINE_AXIS(1)) dut_y (
    .clk(clk), .rst_n(rst_n), .Mode(Mode), .FixedDuty(FixedDuty),
    .AccelX(AccelX), .AccelY(AccelY), .AccelZ(AccelZ),
    .HeartRate(HeartRate), .HeartRateValid(HeartRateValid), .HeartRateSetting(HeartRateSetting),
    .SampleValid(SampleValid), .SampleReady(ready_y), .Duty(duty_y), .Fault(fault_y), .PWMOut(pwm_y)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_wrap();
    int k = 0;
    do begin
      step(1);
      k++;
    end while (dut.cnt != 0 && k < 1100);
    if (k >= 1100) chk("wrap_seen", 32'(dut.cnt), 0);
  endtask
  task automatic wraps(input int n, input bit keep);
    repeat (n) begin
      wait_wrap();
      if (keep) begin
        HeartRateValid = 1'b1;
        step(1);
        HeartRateValid = 1'b0;
      end
    end
  endtask
  task automatic hrv(input logic [7:0] v);
    HeartRate = v;
    HeartRateValid = 1'b1;
    step(1);
    HeartRateValid = 1'b0;
    chk("fault_clear", 32'(Fault), 0);
  endtask
  task automatic sample(input bit poke);
    SampleValid = 1'b1;
    step(1);
    SampleValid = poke;
    for (int i = 0; i < 4; i++) begin
      chk("busy", 32'(SampleReady), 0);
      if (poke && i == 1) FixedDuty = 10'd999;
      step(1);
    end
    SampleValid = 1'b0;
    chk("ready_back", 32'(SampleReady), 1);
    if (poke) begin
      step(1);
      chk("no_retrigger", 32'(SampleReady), 1);
    end
  endtask
  initial begin
    int hi;
    Mode = 2'($urandom); FixedDuty = 10'($urandom); HeartRate = 8'($urandom);
    AccelX = 18'($urandom); AccelY = 18'($urandom); AccelZ = 18'($urandom);
    HeartRateSetting = 8'($urandom); SampleValid = 1'b1; HeartRateValid = 1'b1;
    step(3);
    chk("rst_pwm", 32'(PWMOut), 0);
    chk("rst_duty", 32'(Duty), 0);
    chk("rst_fault", 32'(Fault), 0);
    chk("rst_ready", 32'(SampleReady), 1);
    SampleValid = 1'b0; HeartRateValid = 1'b0; Mode = 2'd0; FixedDuty = '0;
    AccelX = '0; AccelY = '0; AccelZ = '0; HeartRate = '0; HeartRateSetting = 8'd120;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("cnt_start", 32'(dut.cnt), 1);
    hrv(8'd130);
    Mode = 2'd3;
    AccelX = 18'sd4096;
    sample(0);
    chk("tgt_incline", 32'(dut.target), 416);
    chk("tgt_axis_y", 32'(dut_y.target), 160);
    AccelX = -18'sd4096;
    sample(0);
    chk("tgt_neg_accel", 32'(dut.target), 160);
    AccelX = 18'sd131071;
    sample(0);
    chk("tgt_sat", 32'(dut.target), 1023);
    chk("tgt_sat_y", 32'(dut_y.target), 160);
    Mode = 2'd1;
    FixedDuty = 10'd20;
    sample(1);
    chk("tgt_fixed", 32'(dut.target), 20);
    FixedDuty = 10'd20;
    wraps(1, 1);
    chk("ramp_8", 32'(Duty), 8);
    wraps(1, 1);
    chk("ramp_16", 32'(Duty), 16);
    wraps(1, 1);
    chk("ramp_20", 32'(Duty), 20);
    wait_wrap();
    hi = 0;
    repeat (1024) begin
      hi += int'(PWMOut);
      step(1);
    end
    chk("pwm_high", hi, 20);
    Mode = 2'd2;
    hrv(8'd130);
    sample(0);
    chk("tgt_heart", 32'(dut.target), 160);
    wraps(1, 1);
    chk("heart_28", 32'(Duty), 28);
    wraps(17, 1);
    chk("heart_160", 32'(Duty), 160);
    hrv(8'd110);
    sample(0);
    chk("tgt_heart_low", 32'(dut.target), 0);
    for (int i = 1; i <= 5; i++) begin
      wraps(1, 1);
      chk("ramp_down", 32'(Duty), 32'(160 - 32 * i));
    end
    hrv(8'd130);
    sample(0);
    chk("tgt_heart2", 32'(dut.target), 160);
    wraps(20, 1);
    chk("heart2_160", 32'(Duty), 160);
    wraps(7, 0);
    chk("wd_7", 32'(Fault), 0);
    wraps(1, 0);
    chk("wd_fault", 32'(Fault), 1);
    chk("wd_duty_hold", 32'(Duty), 160);
    wraps(1, 0);
    chk("wd_duty_kill", 32'(Duty), 0);
    hrv(8'd130);
    wraps(1, 0);
    chk("wd_recover", 32'(Duty), 8);
    wraps(6, 0);
    step(1023);
    HeartRateValid = 1'b1;
    step(1);
    HeartRateValid = 1'b0;
    chk("wd_race", 32'(Fault), 0);
    chk("wd_race_duty", 32'(Duty), 64);
    step(300);
    Mode = 2'd0;
    step(1);
    chk("off_hold", 32'(Duty), 64);
    wait_wrap();
    chk("off_kill", 32'(Duty), 0);
    step(5);
    chk("off_pwm", 32'(PWMOut), 0);
    Mode = 2'd1;
    FixedDuty = 10'd500;
    sample(0);
    chk("tgt_500", 32'(dut.target), 500);
    wraps(2, 1);
    chk("pre_rst_duty", 32'(Duty), 16);
    step(3);
    SampleValid = 1'b1;
    step(1);
    SampleValid = 1'b0;
    chk("pre_rst_busy", 32'(SampleReady), 0);
    chk("pre_rst_pwm", 32'(PWMOut), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_duty", 32'(Duty), 0);
    chk("arst_pwm", 32'(PWMOut), 0);
    chk("arst_fault", 32'(Fault), 0);
    chk("arst_ready", 32'(SampleReady), 1);
    chk("arst_target", 32'(dut.target), 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rerel_cnt", 32'(dut.cnt), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/assist_pwm_controller.md
# assist_pwm_controller

Parametrised motor-assistance controller for the e-bike drive path. Inputs are rider heart rate, heart-rate setpoint, a fixed-duty command and 3-axis accelerometer data. A multi-cycle state machine computes a target duty cycle. The block ramp-limits the applied duty and drives the motor through a glitch-free PWM output. A heart-rate watchdog forces assistance to zero on stale sensor data.

## Interface
- DATA_W, 18: accelerometer sample width (signed two's complement).
- HR_W, 8: heart-rate width (unsigned, bpm).
- PWM_W, 10: PWM counter/duty width; period = 2^PWM_W clk; DUTY_MAX = 2^PWM_W-1.
- HR_SHIFT, 4: heart-rate gain, left shift of positive HR error.
- TILT_SHIFT, 4: incline gain, arithmetic right shift of positive accel.
- INCLINE_AXIS, 0: axis used as incline (0=X, 1=Y, 2=Z).
- RAMP_UP, 8: max duty increase per PWM period.
- RAMP_DOWN, 32: max duty decrease per PWM period.
- TIMEOUT_PERIODS, 8: PWM periods without HeartRateValid before Fault.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- Mode  in  2  0=OFF, 1=FIXED, 2=HEART, 3=HEART+INCLINE.
- FixedDuty  in  PWM_W  target duty in FIXED mode.
- AccelX, AccelY, AccelZ  in  DATA_W each  signed IMU acceleration.
- HeartRate  in  HR_W  measured heart rate.
- HeartRateValid  in  1  one-cycle strobe; registers HeartRate.
- HeartRateSetting  in  HR_W  rider setpoint.
- SampleValid  in  1  request target recompute.
- SampleReady  out  1  high when the FSM is in IDLE.
- Duty  out  PWM_W  currently applied duty.
- Fault  out  1  heart-rate watchdog expired.
- PWMOut  out  1  motor PWM.

## Operation
- Reset values:
  - Duty=0, Target=0, PWMOut=0, Fault=0, SampleReady=1.
  - PWM counter=0, watchdog=0, HR register=0, FSM=IDLE.
- HeartRateValid registers HeartRate and clears the watchdog, independent of FSM state.
- FSM states: IDLE -> CAPTURE -> HR_TERM -> TILT_TERM -> CLAMP -> IDLE.
  - IDLE: SampleValid && SampleReady advances to CAPTURE. SampleValid is ignored in every other state.
  - CAPTURE: latch Mode, FixedDuty, the selected accel axis and HeartRateSetting.
  - HR_TERM: err = {0,HR} - {0,Setting}, HR_W+1 bits signed. hr_term = err>0 ? err<<HR_SHIFT : 0, saturated to DUTY_MAX.
  - TILT_TERM: tilt = accel>0 ? accel>>>TILT_SHIFT : 0, saturated to DUTY_MAX. Forced to 0 unless Mode=3.
  - CLAMP: Target is written:
    - Mode 0: 0.
    - Mode 1: FixedDuty.
    - Mode 2: hr_term.
    - Mode 3: min(hr_term+tilt, DUTY_MAX), sum computed PWM_W+1 bits wide.
    - Fault=1 and Mode in {2,3}: 0.
- PWM counter increments every clk and wraps from DUTY_MAX to 0. PWMOut = (counter < Duty), registered.
- Duty updates only on the wrap cycle (counter==DUTY_MAX), so every period uses one duty value:
  - Target > Duty: Duty += min(RAMP_UP, Target-Duty).
  - Target < Duty: Duty -= min(RAMP_DOWN, Duty-Target).
  - Mode==0 live, or Fault with live Mode in {2,3}: Duty = 0 immediately at that wrap (safety override, no ramp).
- Watchdog counts wrap cycles and saturates at TIMEOUT_PERIODS. Reaching TIMEOUT_PERIODS sets Fault. HeartRateValid clears the count and Fault.
- Simultaneous HeartRateValid and watchdog expiry on the same cycle: HeartRateValid wins, Fault stays 0.
- rst_n asserted at any point, including mid-compute or mid-ramp: all state returns to reset values asynchronously. Release is synchronous to clk.

## Timing
- SampleValid accepted at cycle N: SampleReady=0 for cycles N+1..N+4, Target valid at N+5, SampleReady=1 at N+5.
- Target reaches Duty at the next wrap, and PWMOut reflects it from the following counter=0 cycle (1-cycle register delay).
- HeartRateValid at cycle N: Fault=0 at N+1.
- Watchdog expiry: Fault rises 1 cycle after the wrap that reaches TIMEOUT_PERIODS.
- PWMOut high time per period = Duty clk cycles. Duty=0 gives constant low. DUTY_MAX gives 1 low cycle per period.

## Test plan
- Reset: hold rst_n=0 with random inputs -> PWMOut=0, Duty=0, Fault=0, SampleReady=1; release mid-period -> counter starts at 0.
- FIXED: Mode=1, FixedDuty=512, one SampleValid -> Duty rises 8 per period, reaches 512 after 64 periods; then PWMOut high exactly 512 of 1024 cycles.
- HEART: Setting=120, HR=130 -> Target=160; then HR=110 and SampleValid -> Target=0, Duty falls 32 per period, reaching 0 after 5 periods.
- HEART+INCLINE: HR=130, Setting=120, AccelX=+4096 -> Target=416. AccelX=-4096 -> Target=160. AccelX=+131071 -> Target=1023 (saturated). INCLINE_AXIS=1 with AccelX=+4096, AccelY=0 -> Target=160.
- Watchdog: Mode=2, Duty=160, no HeartRateValid for 8 periods -> Fault=1, Duty=0 at the next wrap. HeartRateValid on the expiry cycle -> Fault stays 0.
- Protocol: SampleValid pulsed during CAPTURE..CLAMP -> ignored, no second update. Mode->0 mid-period -> Duty=0 at the next wrap. rst_n pulse mid-ramp -> all outputs return to reset values.
